// File: rtl/z480_rob.sv
// Z480 reorder buffer: in-order allocate, out-of-order writeback, in-order commit.
// Optional Z480_ROB_TRAP_FLUSH_EN: a trapping commit also discards all younger entries.
module z480_rob #(
    parameter  int DEPTH  = 64,
    parameter  int NUM_WB = 2,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [63:0]             alloc_pc,
    input  logic                    alloc_rd_valid,
    input  logic [6:0]              alloc_prd,
    output logic [IDX_W-1:0]        alloc_idx,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_idx,
    input  logic [NUM_WB-1:0]       wb_trap,
    input  logic [NUM_WB*32-1:0]    wb_cause,
    output logic                    commit_valid,
    input  logic                    commit_ready,
    output logic [IDX_W-1:0]        commit_idx,
    output logic [63:0]             commit_pc,
    output logic                    commit_rd_valid,
    output logic [6:0]              commit_prd,
    output logic                    commit_has_trap,
    output logic [31:0]             commit_trap_cause,
    output logic [63:0]             commit_trap_epc,
    output logic [IDX_W:0]          count,
    output logic                    empty,
    output logic                    full
);
    localparam logic [IDX_W:0] PTR_ONE = 1;

    logic [IDX_W:0]   r_head, r_tail;
    logic [DEPTH-1:0] r_valid, r_done, r_trap, r_rd_valid;
    logic [31:0]      r_cause [DEPTH];
    logic [63:0]      r_pc    [DEPTH];
    logic [6:0]       r_prd   [DEPTH];

    logic [IDX_W-1:0] w_head_idx, w_tail_idx;
    logic             w_empty, w_full, w_commit_valid, w_commit_fire;
    logic             w_alloc_fire, w_trap_flush;
    logic [IDX_W-1:0] w_wb_idx [NUM_WB];
    logic [NUM_WB-1:0] w_wb_hit;

    assign w_head_idx     = r_head[IDX_W-1:0];
    assign w_tail_idx     = r_tail[IDX_W-1:0];
    assign w_empty        = (r_head == r_tail);
    assign w_full         = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_commit_valid = !w_empty && r_done[w_head_idx] && !flush;
    assign w_commit_fire  = w_commit_valid && commit_ready;
`ifdef Z480_ROB_TRAP_FLUSH_EN
    assign w_trap_flush   = w_commit_fire && r_trap[w_head_idx];
`else
    assign w_trap_flush   = 1'b0;
`endif
    assign alloc_ready    = !w_full && !flush && !w_trap_flush;
    assign w_alloc_fire   = alloc_valid && alloc_ready;

    // A writeback only lands on an entry that is allocated and still pending.
    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            w_wb_idx[p] = wb_idx[p*IDX_W +: IDX_W];
            w_wb_hit[p] = wb_valid[p] && r_valid[w_wb_idx[p]] && !r_done[w_wb_idx[p]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_trap  <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_trap  <= '0;
        end else begin
            // Descending loop: the lowest-numbered port's update is the one that sticks.
            for (int p = NUM_WB-1; p >= 0; p--) begin
                if (w_wb_hit[p]) begin
                    r_done[w_wb_idx[p]] <= 1'b1;
                    r_trap[w_wb_idx[p]] <= wb_trap[p];
                end
            end
            if (w_commit_fire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + PTR_ONE;
            end
            if (w_trap_flush) begin
                r_valid <= '0;
                r_done  <= '0;
                r_head  <= r_tail;
            end else if (w_alloc_fire) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_trap[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + PTR_ONE;
            end
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        for (int p = NUM_WB-1; p >= 0; p--) begin
            if (w_wb_hit[p]) r_cause[w_wb_idx[p]] <= wb_cause[p*32 +: 32];
        end
        if (w_alloc_fire) begin
            r_pc[w_tail_idx]       <= alloc_pc;
            r_rd_valid[w_tail_idx] <= alloc_rd_valid;
            r_prd[w_tail_idx]      <= alloc_prd;
            r_cause[w_tail_idx]    <= '0;
        end
    end

    always_comb begin
        commit_idx        = '0;
        commit_pc         = '0;
        commit_rd_valid   = 1'b0;
        commit_prd        = '0;
        commit_has_trap   = 1'b0;
        commit_trap_cause = '0;
        commit_trap_epc   = '0;
        if (!w_empty) begin
            commit_idx        = w_head_idx;
            commit_pc         = r_pc[w_head_idx];
            commit_rd_valid   = r_rd_valid[w_head_idx];
            commit_prd        = r_prd[w_head_idx];
            commit_has_trap   = r_trap[w_head_idx];
            commit_trap_cause = r_cause[w_head_idx];
            commit_trap_epc   = r_pc[w_head_idx];
        end
    end

    assign commit_valid = w_commit_valid;
    assign alloc_idx    = w_tail_idx;
    assign count        = r_tail - r_head;
    assign empty        = w_empty;
    assign full         = w_full;
endmodule

// File: tb/tb_z480_rob.sv
// Testbench for z480_rob (DEPTH=8, NUM_WB=2) against a queue-based program-order model.
module tb_z480_rob;
    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;
    localparam int IDX_W  = 3;
`ifdef Z480_ROB_TRAP_FLUSH_EN
    localparam bit TRAP_FLUSH = 1'b1;
`else
    localparam bit TRAP_FLUSH = 1'b0;
`endif

    logic clk, rst_n, flush, alloc_valid, alloc_ready, alloc_rd_valid;
    logic [63:0] alloc_pc;
    logic [6:0]  alloc_prd;
    logic [IDX_W-1:0] alloc_idx, commit_idx;
    logic [NUM_WB-1:0] wb_valid, wb_trap;
    logic [NUM_WB*IDX_W-1:0] wb_idx;
    logic [NUM_WB*32-1:0] wb_cause;
    logic commit_valid, commit_ready, commit_rd_valid, commit_has_trap;
    logic [63:0] commit_pc, commit_trap_epc;
    logic [6:0]  commit_prd;
    logic [31:0] commit_trap_cause;
    logic [IDX_W:0] count;
    logic empty, full;

    z480_rob #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_rd_valid(alloc_rd_valid), .alloc_prd(alloc_prd), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_trap(wb_trap), .wb_cause(wb_cause),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_idx(commit_idx),
        .commit_pc(commit_pc), .commit_rd_valid(commit_rd_valid), .commit_prd(commit_prd),
        .commit_has_trap(commit_has_trap), .commit_trap_cause(commit_trap_cause),
        .commit_trap_epc(commit_trap_epc), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        rd_valid;
        logic [6:0]  prd;
        bit          done;
        bit          trap;
        logic [31:0] cause;
    } ent_t;

    ent_t rob_q[$];
    int   m_head;
    int   n_checks;
    int   n_fail;

    function automatic bit m_commit_valid();
        return (rob_q.size() > 0) && rob_q[0].done && !flush;
    endfunction

    function automatic bit m_alloc_ready();
        bit trapc;
        trapc = TRAP_FLUSH && m_commit_valid() && commit_ready && rob_q[0].trap;
        return (rob_q.size() < DEPTH) && !flush && !trapc;
    endfunction

    function automatic int m_alloc_idx();
        return (m_head + rob_q.size()) % DEPTH;
    endfunction

    // Applies the cycle's inputs to the model as of the clock edge.
    task automatic model_update();
        bit do_commit, do_alloc;
        ent_t e;
        do_commit = m_commit_valid() && commit_ready;
        do_alloc  = alloc_valid && m_alloc_ready();
        if (flush) begin
            rob_q.delete();
            m_head = 0;
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p]) begin
                    int pos;
                    pos = (int'(wb_idx[p*IDX_W +: IDX_W]) - m_head + DEPTH) % DEPTH;
                    if (pos < rob_q.size() && !rob_q[pos].done) begin
                        e = rob_q[pos];
                        e.done  = 1'b1;
                        e.trap  = wb_trap[p];
                        e.cause = wb_cause[p*32 +: 32];
                        rob_q[pos] = e;
                    end
                end
            end
            if (do_commit) begin
                e = rob_q.pop_front();
                m_head = (m_head + 1) % DEPTH;
                if (TRAP_FLUSH && e.trap) begin
                    m_head = (m_head + rob_q.size()) % DEPTH;
                    rob_q.delete();
                end
            end
            if (do_alloc) begin
                e.pc = alloc_pc; e.rd_valid = alloc_rd_valid; e.prd = alloc_prd;
                e.done = 1'b0; e.trap = 1'b0; e.cause = '0;
                rob_q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_rd_valid = 1'b0; alloc_prd = '0;
        wb_valid = '0; wb_idx = '0; wb_trap = '0; wb_cause = '0; commit_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    task automatic set_alloc(input logic [63:0] pc);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_rd_valid = pc[2]; alloc_prd = pc[8:2];
    endtask

    task automatic set_wb(input int p, input int idx, input bit trap, input logic [31:0] cause);
        wb_valid[p] = 1'b1;
        wb_idx[p*IDX_W +: IDX_W] = idx[IDX_W-1:0];
        wb_trap[p] = trap;
        wb_cause[p*32 +: 32] = cause;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rob_q.delete(); m_head = 0;
        #1;
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
        n_checks++; if (alloc_idx !== 3'd0 || full !== 1'b0) begin n_fail++; $display("FAIL reset_idx_full got idx=%0d full=%b want 0/0", alloc_idx, full); end
        n_checks++; if (commit_pc !== 64'd0) begin n_fail++; $display("FAIL reset_commit_pc got %h want 0", commit_pc); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(64'h100 + 64'(4*i));
            #1;
            n_checks++; if (alloc_idx !== 3'(i) || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_alloc got idx=%0d rdy=%b want idx=%0d rdy=1", alloc_idx, alloc_ready, i); end
            tick();
        end
        #1;
        n_checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL full_state got full=%b rdy=%b cnt=%0d want 1/0/8", full, alloc_ready, count); end
        set_alloc(64'h999);
        tick();
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_reject got cnt=%0d want 8", count); end
        for (int i = 0; i < DEPTH/2; i++) begin
            set_wb(0, 2*i + 1, 1'b0, 32'h0);
            set_wb(1, 2*i, 1'b0, 32'h0);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            commit_ready = 1'b1;
            #1;
            n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 64'h100 + 64'(4*i) || commit_idx !== 3'(i)) begin n_fail++; $display("FAIL fill_commit got v=%b pc=%h idx=%0d want v=1 pc=%h idx=%0d", commit_valid, commit_pc, commit_idx, 64'h100 + 64'(4*i), i); end
            n_checks++; if (commit_rd_valid !== rob_q[0].rd_valid || commit_prd !== rob_q[0].prd) begin n_fail++; $display("FAIL fill_commit_rd got %b/%0d want %b/%0d", commit_rd_valid, commit_prd, rob_q[0].rd_valid, rob_q[0].prd); end
            tick();
        end
        n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL drain_empty got e=%b cnt=%0d want 1/0", empty, count); end
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(64'h180 + 64'(4*i));
            #1;
            n_checks++; if (alloc_idx !== 3'(i)) begin n_fail++; $display("FAIL wrap_alloc_idx got %0d want %0d", alloc_idx, i); end
            tick();
        end
    endtask

    task automatic test_ooo_wb();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            set_alloc(64'h200 + 64'(4*i));
            tick();
        end
        set_wb(0, 2, 1'b0, 32'h0);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b1;
        set_wb(1, 0, 1'b0, 32'h0);
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait got v=%b want 0", commit_valid); end
        tick();
        commit_ready = 1'b1;
        set_wb(0, 1, 1'b0, 32'h0);
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_idx !== 3'd0) begin n_fail++; $display("FAIL ooo_c0 got v=%b idx=%0d want 1/0", commit_valid, commit_idx); end
        tick();
        for (int i = 1; i < 3; i++) begin
            commit_ready = 1'b1;
            #1;
            n_checks++; if (commit_valid !== 1'b1 || commit_idx !== 3'(i) || commit_pc !== 64'h200 + 64'(4*i)) begin n_fail++; $display("FAIL ooo_order got v=%b idx=%0d pc=%h want 1/%0d", commit_valid, commit_idx, commit_pc, i); end
            tick();
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ooo_empty got %b want 1", empty); end
    endtask

    task automatic test_dual_wb();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            set_alloc(64'h300 + 64'(4*i));
            tick();
        end
        set_wb(0, 0, 1'b0, 32'h0); set_wb(1, 1, 1'b0, 32'h0);
        tick();
        set_wb(0, 2, 1'b0, 32'h0);
        tick();
        set_wb(0, 3, 1'b1, 32'h5); set_wb(1, 3, 1'b0, 32'h9);
        tick();
        for (int i = 0; i < 3; i++) begin
            commit_ready = 1'b1;
            tick();
        end
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_idx !== 3'd3 || commit_has_trap !== 1'b1) begin n_fail++; $display("FAIL dual_trap got v=%b idx=%0d trap=%b want 1/3/1", commit_valid, commit_idx, commit_has_trap); end
        n_checks++; if (commit_trap_cause !== 32'h5 || commit_trap_epc !== 64'h30C) begin n_fail++; $display("FAIL dual_cause got cause=%h epc=%h want 5/30c", commit_trap_cause, commit_trap_epc); end
        do_flush();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_alloc(64'h400 + 64'(4*i));
            tick();
        end
        set_wb(0, 0, 1'b0, 32'h0);
        tick();
        flush = 1'b1; commit_ready = 1'b1;
        set_alloc(64'h500);
        set_wb(0, 1, 1'b0, 32'h0);
        #1;
        n_checks++; if (count !== 4'd5 || alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got cnt=%0d rdy=%b v=%b want 5/0/0", count, alloc_ready, commit_valid); end
        tick();
        n_checks++; if (count !== 4'd0 || empty !== 1'b1 || alloc_idx !== 3'd0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after got cnt=%0d e=%b idx=%0d v=%b want 0/1/0/0", count, empty, alloc_idx, commit_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(64'h800 + 64'(4*i));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL async_reset got cnt=%0d e=%b want 0/1", count, empty); end
        rob_q.delete(); m_head = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_trap_commit();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            set_alloc(64'h600 + 64'(4*i));
            tick();
        end
        set_wb(0, 0, 1'b1, 32'h2); set_wb(1, 1, 1'b0, 32'h0);
        tick();
        set_wb(0, 2, 1'b0, 32'h0); set_wb(1, 3, 1'b0, 32'h0);
        tick();
        commit_ready = 1'b1;
        #1;
        n_checks++; if (commit_has_trap !== 1'b1 || commit_trap_cause !== 32'h2 || commit_trap_epc !== 64'h600) begin n_fail++; $display("FAIL trap_head got trap=%b cause=%h epc=%h want 1/2/600", commit_has_trap, commit_trap_cause, commit_trap_epc); end
        n_checks++; if (alloc_ready !== !TRAP_FLUSH) begin n_fail++; $display("FAIL trap_alloc_ready got %b want %b", alloc_ready, !TRAP_FLUSH); end
        tick();
`ifdef Z480_ROB_TRAP_FLUSH_EN
        n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL trap_flush got cnt=%0d e=%b want 0/1", count, empty); end
`else
        n_checks++; if (count !== 4'd3 || empty !== 1'b0) begin n_fail++; $display("FAIL trap_retire got cnt=%0d e=%b want 3/0", count, empty); end
        commit_ready = 1'b1;
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_pc !== 64'h604 || commit_has_trap !== 1'b0) begin n_fail++; $display("FAIL trap_next got v=%b pc=%h trap=%b want 1/604/0", commit_valid, commit_pc, commit_has_trap); end
        tick();
`endif
        n_checks++; if (count !== 4'(rob_q.size())) begin n_fail++; $display("FAIL trap_model_count got %0d want %0d", count, rob_q.size()); end
        do_flush();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            alloc_valid = ($urandom_range(0, 9) < 7);
            alloc_pc = {$urandom(), $urandom()};
            alloc_rd_valid = 1'($urandom_range(0, 1));
            alloc_prd = 7'($urandom_range(0, 127));
            commit_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < NUM_WB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int idx;
                    if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                        idx = (m_head + $urandom_range(0, rob_q.size() - 1)) % DEPTH;
                    else
                        idx = $urandom_range(0, DEPTH - 1);
                    set_wb(p, idx, ($urandom_range(0, 7) == 0), $urandom());
                end
            end
            #1;
            n_checks++; if (alloc_ready !== m_alloc_ready() || alloc_idx !== 3'(m_alloc_idx())) begin n_fail++; $display("FAIL rnd_alloc cyc=%0d got rdy=%b idx=%0d want %b/%0d", cyc, alloc_ready, alloc_idx, m_alloc_ready(), m_alloc_idx()); end
            n_checks++; if (count !== 4'(rob_q.size()) || empty !== (rob_q.size() == 0) || full !== (rob_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_occ cyc=%0d got cnt=%0d e=%b f=%b want cnt=%0d", cyc, count, empty, full, rob_q.size()); end
            n_checks++; if (commit_valid !== m_commit_valid()) begin n_fail++; $display("FAIL rnd_cvalid cyc=%0d got %b want %b", cyc, commit_valid, m_commit_valid()); end
            if (rob_q.size() > 0) begin
                n_checks++;
                if (commit_idx !== 3'(m_head) || commit_pc !== rob_q[0].pc || commit_rd_valid !== rob_q[0].rd_valid ||
                    commit_prd !== rob_q[0].prd || commit_trap_epc !== rob_q[0].pc ||
                    (rob_q[0].done && (commit_has_trap !== rob_q[0].trap || commit_trap_cause !== rob_q[0].cause))) begin
                    n_fail++;
                    $display("FAIL rnd_head cyc=%0d got idx=%0d pc=%h trap=%b cause=%h want idx=%0d pc=%h trap=%b cause=%h",
                             cyc, commit_idx, commit_pc, commit_has_trap, commit_trap_cause, m_head, rob_q[0].pc, rob_q[0].trap, rob_q[0].cause);
                end
            end else begin
                n_checks++; if (commit_pc !== 64'd0 || commit_idx !== 3'd0 || commit_has_trap !== 1'b0) begin n_fail++; $display("FAIL rnd_empty_data cyc=%0d got pc=%h idx=%0d trap=%b want 0", cyc, commit_pc, commit_idx, commit_has_trap); end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_head   = 0;
        rst_n    = 1'b0;
        idle();
        test_reset();
        test_fill_wrap();
        test_ooo_wb();
        test_dual_wb();
        test_flush();
        test_async_reset();
        test_trap_commit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
